// File: rtl/pooling_stream.sv
// pooling_stream: streaming 2D pooling over square raster frames.
// Pixels arrive in row-major order. One partial result per window column is
// kept in a row buffer, and each finished window is emitted through a
// single-entry valid/ready output register.
// Optional feature: define POOL_AVG_EN to add the 'mode' port (0 = max, 1 = average).
module pooling_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int INPUT_SIZE = 8,
    parameter int POOL_SIZE  = 2,
    localparam int OUT_SIZE  = INPUT_SIZE / POOL_SIZE,
    localparam int IDX_W     = (OUT_SIZE * OUT_SIZE > 1) ? $clog2(OUT_SIZE * OUT_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done
`ifdef POOL_AVG_EN
    ,
    input  logic                  mode
`endif
);

    localparam int PLOG  = $clog2(POOL_SIZE);
    localparam int CNT_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int WIN_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int LAST  = INPUT_SIZE - 1;
    localparam int USED  = OUT_SIZE * POOL_SIZE;
`ifdef POOL_AVG_EN
    // Averaging needs headroom for the sum of POOL_SIZE*POOL_SIZE pixels.
    localparam int ACC_W = DATA_WIDTH + 2 * PLOG;
`else
    localparam int ACC_W = DATA_WIDTH;
`endif

    logic [CNT_W-1:0]        r_row;
    logic [CNT_W-1:0]        r_col;
    logic signed [ACC_W-1:0] r_buf [OUT_SIZE];

    logic                    w_accept;
    logic                    w_inWindow;
    logic                    w_origin;
    logic                    w_closing;
    logic                    w_lastPixel;
    logic                    w_avg;
    logic [WIN_W-1:0]        w_win;
    logic [IDX_W-1:0]        w_idx;
    logic signed [ACC_W-1:0] w_pix;
    logic signed [ACC_W-1:0] w_entry;
    logic signed [ACC_W-1:0] w_next;
    logic [DATA_WIDTH-1:0]   w_result;

    assign in_ready    = !out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_inWindow  = (int'(r_row) < USED) && (int'(r_col) < USED);
    assign w_origin    = (int'(r_row) % POOL_SIZE == 0) && (int'(r_col) % POOL_SIZE == 0);
    assign w_closing   = (int'(r_row) % POOL_SIZE == POOL_SIZE - 1) &&
                         (int'(r_col) % POOL_SIZE == POOL_SIZE - 1);
    assign w_lastPixel = (int'(r_row) == LAST) && (int'(r_col) == LAST);
    assign w_win       = w_inWindow ? WIN_W'(int'(r_col) / POOL_SIZE) : '0;
    assign w_idx       = IDX_W'((int'(r_row) / POOL_SIZE) * OUT_SIZE + int'(r_col) / POOL_SIZE);
    assign w_pix       = ACC_W'($signed(in_data));
    assign w_entry     = r_buf[w_win];

`ifdef POOL_AVG_EN
    assign w_avg = mode;
`else
    assign w_avg = 1'b0;
`endif

    // Combine the incoming pixel with the window's partial result and form the finished value.
    always_comb begin
        w_next = w_pix;
        if (!w_origin) begin
            if (w_avg) begin
                w_next = w_entry + w_pix;
            end else if (w_entry > w_pix) begin
                w_next = w_entry;
            end
        end
        if (w_avg) begin
            w_result = DATA_WIDTH'(w_next >>> (2 * PLOG));
        end else begin
            w_result = DATA_WIDTH'(w_next);
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == CNT_W'(LAST)) begin
                r_col <= '0;
                if (r_row == CNT_W'(LAST)) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Row buffer of partial window results; every entry is reloaded at its window origin before use.
    always_ff @(posedge clk) begin
        if (w_accept && w_inWindow) begin
            r_buf[w_win] <= w_next;
        end
    end

    // Output register: load a finished window, hold while stalled, clear once popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_accept && w_lastPixel;
            if (w_accept && w_inWindow && w_closing) begin
                out_valid <= 1'b1;
                out_data  <= w_result;
                out_idx   <= w_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pooling_stream.md
POOLING_STREAM -- requirements
Module: pooling_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: pixel width, two's-complement signed.
REQ-002 SHALL have parameter INPUT_SIZE, default 8: square frame edge length in pixels, at least 2.
REQ-003 SHALL have parameter POOL_SIZE, default 2: square window edge, non-overlapping stride equal to POOL_SIZE, a power of two, at most INPUT_SIZE.
REQ-004 SHALL have the following ports, clock and reset first:
  - clk  input  1  rising-edge clock.
  - reset  input  1  synchronous, active-high reset.
  - in_data  input  DATA_WIDTH  pixel, raster order (row-major).
  - in_valid  input  1  in_data valid.
  - in_ready  output  1  block accepts a pixel this cycle.
  - out_data  output  DATA_WIDTH  pooled result.
  - out_idx  output  clog2(OUT_SIZE*OUT_SIZE), min 1  raster index of the result, where OUT_SIZE = INPUT_SIZE/POOL_SIZE (floor).
  - out_valid  output  1  out_data/out_idx valid.
  - out_ready  input  1  downstream accepts.
  - frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.
  - mode  input  1  0 = max, 1 = average; present only with POOL_AVG_EN (REQ-020).

Function
REQ-005 SHALL accept a pixel on each cycle where in_valid and in_ready are both high; in_ready = !out_valid || out_ready.
REQ-006 SHALL track row and column counters (0..INPUT_SIZE-1); column increments per accepted pixel, wraps to 0 and increments row; row wraps to 0 after the last column of the last row.
REQ-007 SHALL keep a row buffer of OUT_SIZE partial-result entries, indexed by window column w = col/POOL_SIZE.
REQ-008 On an accepted pixel at row%POOL_SIZE==0 and col%POOL_SIZE==0 (window origin), the block SHALL load the entry with in_data.
REQ-009 On any other accepted in-window pixel, the block SHALL replace the entry with the signed maximum of the entry and in_data.
REQ-010 When the accepted pixel has row%POOL_SIZE==POOL_SIZE-1 and col%POOL_SIZE==POOL_SIZE-1, the block SHALL assert out_valid on the next cycle, with out_data = final window result and out_idx = (row/POOL_SIZE)*OUT_SIZE + w; latency is 1 cycle.
REQ-011 SHALL ignore pixels with col >= OUT_SIZE*POOL_SIZE or row >= OUT_SIZE*POOL_SIZE (truncation); these are still accepted and still advance the counters.
REQ-012 SHALL hold out_data/out_idx/out_valid stable while out_valid && !out_ready; when out_ready is high, out_valid clears unless a new result completes in the same cycle (the same cycle is allowed to both pop and load).
REQ-013 SHALL pulse frame_done for exactly one cycle, the cycle after the pixel at (INPUT_SIZE-1, INPUT_SIZE-1) is accepted; the next accepted pixel belongs to a new frame.
REQ-014 SHALL produce exactly OUT_SIZE*OUT_SIZE results per frame, in increasing out_idx order.
REQ-015 SHALL NOT drop or duplicate results under any out_ready pattern.

Reset
REQ-016 While reset is high at a clock edge, the block SHALL set the counters to 0 and set out_valid, frame_done and out_idx to 0, and out_data to 0; in_ready SHALL read 1 after reset.
REQ-017 Row buffer contents SHALL be don't-care after reset (overwritten by REQ-008 before use).
REQ-018 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after reset is pixel (0,0).

Configuration
REQ-019 Without POOL_AVG_EN defined, there SHALL be no mode port and only max pooling.
REQ-020 With POOL_AVG_EN defined:
  - mode port present, sampled per accepted pixel; mode SHALL be held constant within a frame, otherwise the result is undefined.
  - mode=1: entries accumulate a signed sum of width DATA_WIDTH + 2*clog2(POOL_SIZE).
  - Result = sum arithmetic-shifted right by 2*clog2(POOL_SIZE) (floor), truncated to DATA_WIDTH.
  - mode=0: identical to the max behaviour.

Verification
REQ-021 INPUT_SIZE=4, POOL_SIZE=2, pixels 0..15, out_ready=1 -> outputs (idx, data) (0,5), (1,7), (2,13), (3,15); frame_done one cycle after pixel 15.
REQ-022 INPUT_SIZE=4, POOL_SIZE=2, all pixels -10 except pixel 5 = -3 -> out_data -3, -10, -10, -10.
REQ-023 REQ-021 stimulus with out_ready low for 5 cycles at the first result -> in_ready low while stalled, outputs unchanged and in order, no loss.
REQ-024 INPUT_SIZE=5, POOL_SIZE=2, pixels 0..24 -> 4 results: 6, 8, 16, 18; column 4 and row 4 ignored; frame_done after pixel 24.
REQ-025 Reset asserted after 7 pixels, then pixels 0..15 -> results identical to REQ-021.
REQ-026 POOL_AVG_EN, mode=1, INPUT_SIZE=4, pixels 0..15 -> 2, 4, 10, 12; window {-1,-2,-1,-2} -> -2.
